// File: rtl/risc16_tick_sequencer.sv
// RISC_16 front end: 5-phase one-hot tick, fetch-phase instruction latch,
// retired-instruction counter and halt-on-opcode.
module risc16_tick_sequencer #(
    parameter logic [3:0] HALT_OPCODE = 4'hF,
    parameter int         COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [15:0]        instruction,
    output logic [4:0]         tick_out,
    output logic [15:0]        instr_reg,
    output logic [3:0]         opcode,
    output logic [3:0]         rx,
    output logic [3:0]         ry,
    output logic [3:0]         rz,
    output logic               retire,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALT
    } state_t;

    state_t state;
    logic   retire_q;

    assign opcode = instr_reg[15:12];
    assign rx     = instr_reg[11:8];
    assign ry     = instr_reg[7:4];
    assign rz     = instr_reg[3:0];

    // A frozen cycle masks the pulse, and the register is cleared so it is not replayed.
    assign retire = retire_q & enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tick_out    <= 5'b00000;
            instr_reg   <= 16'h0000;
            retire_q    <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else if (!enable) begin
            retire_q <= 1'b0;
        end else begin
            retire_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    state    <= S_T1;
                    tick_out <= 5'b10000;
                end
                S_T1: begin
                    state     <= S_T2;
                    tick_out  <= 5'b01000;
                    instr_reg <= instruction;
                end
                S_T2: begin
                    state    <= S_T3;
                    tick_out <= 5'b00100;
                end
                S_T3: begin
                    state    <= S_T4;
                    tick_out <= 5'b00010;
                end
                S_T4: begin
                    state    <= S_T5;
                    tick_out <= 5'b00001;
                end
                S_T5: begin
                    retire_q    <= 1'b1;
                    instr_count <= instr_count + COUNT_W'(1);
                    if (opcode == HALT_OPCODE) begin
                        state    <= S_HALT;
                        tick_out <= 5'b00000;
                        halted   <= 1'b1;
                    end else begin
                        state    <= S_T1;
                        tick_out <= 5'b10000;
                    end
                end
                S_HALT: begin
                    state    <= S_HALT;
                    tick_out <= 5'b00000;
                end
                default: begin
                    state    <= S_IDLE;
                    tick_out <= 5'b00000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc16_tick_sequencer.sv
// Scoreboard bench for risc16_tick_sequencer: a default instance plus a
// COUNT_W=3 instance sharing stimulus so counter wrap is observed.
module tb_risc16_tick_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] instruction;

    logic [4:0]  tick_out;
    logic [15:0] instr_reg;
    logic [3:0]  opcode, rx, ry, rz;
    logic        retire, halted;
    logic [15:0] instr_count;

    logic [4:0]  tick_out_w3;
    logic [15:0] instr_reg_w3;
    logic [3:0]  opcode_w3, rx_w3, ry_w3, rz_w3;
    logic        retire_w3, halted_w3;
    logic [2:0]  instr_count_w3;

    always #5 clk = ~clk;

    risc16_tick_sequencer dut (
        .clk(clk), .rst(rst), .enable(enable), .instruction(instruction),
        .tick_out(tick_out), .instr_reg(instr_reg), .opcode(opcode),
        .rx(rx), .ry(ry), .rz(rz), .retire(retire), .halted(halted),
        .instr_count(instr_count)
    );

    risc16_tick_sequencer #(.HALT_OPCODE(4'hF), .COUNT_W(3)) dut_w3 (
        .clk(clk), .rst(rst), .enable(enable), .instruction(instruction),
        .tick_out(tick_out_w3), .instr_reg(instr_reg_w3), .opcode(opcode_w3),
        .rx(rx_w3), .ry(ry_w3), .rz(rz_w3), .retire(retire_w3), .halted(halted_w3),
        .instr_count(instr_count_w3)
    );

    always @(negedge clk) begin
        a_tick_onehot: assert ($onehot0(tick_out) && $onehot0(tick_out_w3))
            else $error("tick_out not one-hot: %b %b", tick_out, tick_out_w3);
    end

    typedef struct {
        logic [15:0] instr;
        logic [15:0] count;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_count;
    logic [15:0] prev_instr;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock; on a retire pulse the oldest expected instruction is popped and compared.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (retire) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_retire", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr", {16'h0, instr_reg}, {16'h0, e.instr});
                chk("sb_count", {16'h0, instr_count}, {16'h0, e.count});
                chk("sb_count_w3", {29'h0, instr_count_w3}, {29'h0, e.count[2:0]});
            end
        end
    endtask

    // Entered with the DUT sampled in T1; leaves it sampled just after the edge out of T5.
    task automatic run_instr(input logic [15:0] instr, input bit gate_t3);
        chk("t1_tick", {27'h0, tick_out}, 32'h10);
        chk("t1_hold", {16'h0, instr_reg}, {16'h0, prev_instr});
        instruction = instr;
        exp_count   = exp_count + 16'd1;
        exp_q.push_back('{instr, exp_count});
        step();
        chk("t2_tick", {27'h0, tick_out}, 32'h08);
        chk("t2_latch", {16'h0, instr_reg}, {16'h0, instr});
        chk("opcode", {28'h0, opcode}, {28'h0, instr[15:12]});
        chk("rx", {28'h0, rx}, {28'h0, instr[11:8]});
        chk("ry", {28'h0, ry}, {28'h0, instr[7:4]});
        chk("rz", {28'h0, rz}, {28'h0, instr[3:0]});
        chk("t2_retire", {31'h0, retire}, 32'h0);
        instruction = 16'($urandom);
        step();
        chk("t3_tick", {27'h0, tick_out}, 32'h04);
        if (gate_t3) begin
            enable = 1'b0;
            repeat (3) begin
                step();
                chk("gate_tick", {27'h0, tick_out}, 32'h04);
                chk("gate_retire", {31'h0, retire}, 32'h0);
                chk("gate_count", {16'h0, instr_count}, {16'h0, exp_count - 16'd1});
            end
            enable = 1'b1;
        end
        step();
        chk("t4_tick", {27'h0, tick_out}, 32'h02);
        instruction = 16'($urandom);
        step();
        chk("t5_tick", {27'h0, tick_out}, 32'h01);
        chk("t5_latch", {16'h0, instr_reg}, {16'h0, instr});
        step();
        chk("retire_pulse", {31'h0, retire}, 32'h1);
        if (instr[15:12] == 4'hF) begin
            chk("halt_tick", {27'h0, tick_out}, 32'h00);
            chk("halted", {31'h0, halted}, 32'h1);
        end else begin
            chk("next_t1_tick", {27'h0, tick_out}, 32'h10);
            chk("not_halted", {31'h0, halted}, 32'h0);
        end
        prev_instr = instr;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_tick"}, {27'h0, tick_out}, 32'h0);
        chk({tag, "_instr_reg"}, {16'h0, instr_reg}, 32'h0);
        chk({tag, "_retire"}, {31'h0, retire}, 32'h0);
        chk({tag, "_halted"}, {31'h0, halted}, 32'h0);
        chk({tag, "_count"}, {16'h0, instr_count}, 32'h0);
        chk({tag, "_count_w3"}, {29'h0, instr_count_w3}, 32'h0);
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b1;
        instruction = 16'h1203;
        exp_count   = 16'd0;
        prev_instr  = 16'h0;

        step();
        check_reset_state("reset");
        rst = 1'b0;
        step();
        chk("first_t1", {27'h0, tick_out}, 32'h10);

        run_instr(16'h1203, 1'b0);
        chk("count_after_1", {16'h0, instr_count}, 32'd1);
        run_instr(16'h5A01, 1'b0);
        chk("count_after_2", {16'h0, instr_count}, 32'd2);
        run_instr(16'h3456, 1'b1);

        // Drop enable in the cycle holding the retire pulse: masked, then not replayed.
        enable = 1'b0;
        #1;
        chk("retire_masked", {31'h0, retire}, 32'h0);
        step();
        chk("frozen_t1", {27'h0, tick_out}, 32'h10);
        chk("frozen_retire", {31'h0, retire}, 32'h0);
        enable = 1'b1;
        #1;
        chk("no_reemit", {31'h0, retire}, 32'h0);

        run_instr(16'h7777, 1'b0);
        run_instr(16'hF000, 1'b0);
        chk("halt_count", {16'h0, instr_count}, 32'd5);
        for (int i = 0; i < 20; i++) begin
            instruction = 16'($urandom);
            step();
            chk("halt_hold_tick", {27'h0, tick_out}, 32'h0);
            chk("halt_hold_flag", {31'h0, halted}, 32'h1);
            chk("halt_hold_count", {16'h0, instr_count}, 32'd5);
            chk("halt_hold_instr", {16'h0, instr_reg}, 32'h0000F000);
            chk("halt_hold_retire", {31'h0, retire}, 32'h0);
        end

        rst = 1'b1;
        step();
        check_reset_state("halt_reset");
        rst = 1'b0;
        exp_count  = 16'd0;
        prev_instr = 16'h0;
        step();

        // Abort the third instruction during T4.
        run_instr(16'h1111, 1'b0);
        run_instr(16'h2222, 1'b0);
        chk("abort_t1", {27'h0, tick_out}, 32'h10);
        instruction = 16'h3333;
        step();
        step();
        step();
        chk("abort_t4", {27'h0, tick_out}, 32'h02);
        rst = 1'b1;
        step();
        check_reset_state("mid_reset");
        rst = 1'b0;
        exp_count  = 16'd0;
        prev_instr = 16'h0;
        step();
        run_instr(16'h4444, 1'b0);
        chk("restart_count", {16'h0, instr_count}, 32'd1);

        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_count  = 16'd0;
        prev_instr = 16'h0;
        step();
        for (int i = 0; i < 9; i++) begin
            run_instr({4'h2, 12'(i)}, 1'b0);
        end
        chk("wrap_final_w3", {29'h0, instr_count_w3}, 32'd1);
        chk("wrap_final_w16", {16'h0, instr_count}, 32'd9);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/risc16_tick_sequencer.md
Name: risc16_tick_sequencer

Overview:
Processor-side control front end for RISC_16. It answers the instruction/tick interface that the board harness drives: it generates the one-hot 5-phase tick, samples the 16-bit instruction during the fetch phase, and holds the decoded fields steady for the later phases. It also counts retired instructions and halts on a designated opcode. It sits inside RISC_16 between the external instruction input and the datapath control decode.

Parameters:
HALT_OPCODE, 4'hF, opcode value that stops sequencing after its T5 phase
COUNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock; on the board this is the manual KEY[0] press
rst  input  1  synchronous, active-high reset
enable  input  1  when low, all state is frozen (tick, registers, counter)
instruction  input  16  instruction word; must be stable while tick_out==5'b10000
tick_out  output  5  one-hot phase: 10000=T1 fetch, 01000=T2, 00100=T3, 00010=T4, 00001=T5; 00000=idle/halted
instr_reg  output  16  latched instruction
opcode  output  4  instr_reg[15:12]
rx  output  4  instr_reg[11:8]
ry  output  4  instr_reg[7:4]
rz  output  4  instr_reg[3:0]
retire  output  1  one-cycle pulse in the cycle after T5 completes
halted  output  1  high once a HALT_OPCODE instruction retires
instr_count  output  COUNT_W  number of retired instructions

Behaviour:
- Reset (rst=1 at a clk edge) applies regardless of enable: tick_out=00000, instr_reg=0, retire=0, halted=0, instr_count=0. Reset mid-phase aborts the instruction in flight, and that instruction is not counted.
- States: IDLE (00000), T1, T2, T3, T4, T5, HALT (tick 00000, halted=1).
- Transitions occur only on clk edges with enable=1:
  - IDLE->T1
  - T1->T2, with instr_reg<=instruction sampled on this edge
  - T2->T3, T3->T4, T4->T5
  - T5->T1 if the opcode is not HALT_OPCODE
  - T5->HALT if the opcode equals HALT_OPCODE
  - HALT->HALT until rst
- The first T1 after reset appears one enabled edge after reset is released.
- A steady-state instruction takes 5 cycles from T1 to T5, then the next T1 follows immediately.
- instr_reg holds from the T1->T2 edge until the next T1->T2 edge. It does not change during T1 of the next instruction, so the fields shown during T1 belong to the previous instruction.
- opcode, rx, ry and rz are combinational slices of instr_reg.
- retire: registered. It is 1 for exactly one cycle after the edge leaving T5, including T5->HALT, and 0 otherwise.
- enable=0 freezes all state and forces the retire output to 0 in that cycle. When enable returns to 1, the pending retire pulse is not re-emitted.
- instr_count increments by 1 on every edge leaving T5. It wraps to 0 past 2^COUNT_W-1, with no saturation and no flag.
- halted=1 from the T5->HALT edge onward. In HALT, the instruction input is ignored and instr_reg and instr_count hold.
- tick_out is always one-hot or all-zero; no other pattern is legal. An assertion in the bench checks this every cycle.
- Simultaneous rst and enable: rst wins.

Test Plan:
- Reset then basic cycle: rst 1 cycle, enable=1, instruction=16'h1203 -> tick sequence 00000,10000,01000,00100,00010,00001,10000; instr_reg=16'h1203 from the 2nd edge after reset release; opcode=1, rx=2, ry=0, rz=3; retire pulses once; instr_count=1.
- Back-to-back: 16'h1203 then 16'h5A01, changing the input only during T2..T5 -> the second instruction is latched on its T1->T2 edge; instr_count=2 after 10 phases; instr_reg holds 16'h1203 throughout the second T1.
- Enable gating: drop enable for 3 cycles during T3 -> tick_out stays 00100 and the counter is unchanged; the sequence resumes at T4 on re-enable; retire is never asserted while enable=0.
- Halt: instruction=16'hF000 -> after T5, tick_out=00000, halted=1, retire pulses once, instr_count incremented; 20 further cycles with varying instruction -> no change; rst -> halted=0, tick_out=00000.
- Reset mid-operation: assert rst during T4 of the 3rd instruction -> all outputs zero, instr_count=0; the next instruction starts at T1 cleanly.
- Counter wrap: set COUNT_W=3 and run 9 instructions -> instr_count sequence 1..7,0,1.
